im2col_addr_gen: RTL and testbench

//  Parametrised im2col read-address generator for the GEMM datapath; successor to the fixed square-tensor generator.

---
 rtl/im2col_pkg.sv | 39 +++
 rtl/im2col_addr_gen_if.sv | 15 +
 rtl/im2col_win_cnt.sv | 44 ++++
 rtl/im2col_addr_gen.sv | 144 ++++++++++++++
 tb/tb_im2col_addr_gen.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im2col_pkg.sv
// Shared definitions for the im2col read-address generator: widths, FSM states,
// layer configuration record and the configuration legality rule.
package im2col_pkg;

  localparam int CFG_DIM_W  = 8;
  localparam int CFG_K_W    = 4;
  localparam int CFG_CH_W   = 8;
  localparam int CFG_S_W    = 4;
  localparam int CFG_P_W    = 3;
  localparam int CFG_ADDR_W = 24;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [CFG_DIM_W-1:0]  height;
    logic [CFG_DIM_W-1:0]  width;
    logic [CFG_CH_W-1:0]   channels;
    logic [CFG_K_W-1:0]    kernel;
    logic [CFG_S_W-1:0]    stride;
    logic [CFG_P_W-1:0]    pad;
    logic [CFG_ADDR_W-1:0] base;
  } cfg_t;

  // A layer needs non-empty dims and a kernel that fits the padded tensor.
  function automatic logic cfg_legal(cfg_t cfg);
    int two_p;
    two_p = 2 * int'(cfg.pad);
    return (cfg.kernel != '0) && (cfg.stride != '0) && (cfg.channels != '0) &&
           (cfg.height != '0) && (cfg.width != '0) &&
           (int'(cfg.kernel) <= int'(cfg.height) + two_p) &&
           (int'(cfg.kernel) <= int'(cfg.width) + two_p);
  endfunction

endpackage

// File: rtl/im2col_addr_gen_if.sv
// Read-address stream from the im2col generator to the tensor SRAM read port.
interface im2col_addr_gen_if
  import im2col_pkg::*;
#(
  parameter int ADDR_W = CFG_ADDR_W
);
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] o_addr;
  logic              o_pad;
  logic              o_last;

  modport master (output o_valid, o_addr, o_pad, o_last, input i_ready);
  modport slave  (input o_valid, o_addr, o_pad, o_last, output i_ready);
endinterface

// File: rtl/im2col_win_cnt.sv
// One spatial axis of the im2col walk: window origin (steps by stride) and the
// kernel offset inside the window. Origin is stored relative to -pad.
module im2col_win_cnt
  import im2col_pkg::*;
#(
  parameter int DIM_W = CFG_DIM_W,
  parameter int K_W   = CFG_K_W,
  parameter int S_W   = CFG_S_W,
  parameter int P_W   = CFG_P_W,
  localparam int CW   = DIM_W + 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 adv_off,
  input  logic                 adv_org,
  input  logic [DIM_W-1:0]     dim,
  input  logic [K_W-1:0]       kernel,
  input  logic [S_W-1:0]       stride,
  input  logic [P_W-1:0]       pad,
  output logic signed [CW-1:0] coord,
  output logic                 off_last,
  output logic                 org_last
);

  logic [CW-1:0]  org_rel;
  logic [K_W-1:0] off;

  assign off_last = (off == kernel - K_W'(1));
  // Next window would overhang the padded edge: partial windows are dropped.
  assign org_last = (int'(org_rel) + int'(stride) + int'(kernel)) > (int'(dim) + 2 * int'(pad));
  assign coord    = $signed(org_rel + CW'(off) - CW'(pad));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      org_rel <= '0;
      off     <= '0;
    end else begin
      // NOTE: non-blocking updates so both counters see the same pre-edge values.
      if (adv_off) off <= off_last ? '0 : off + K_W'(1);
      if (adv_org) org_rel <= org_last ? '0 : org_rel + CW'(stride);
    end
  end

endmodule

// File: rtl/im2col_addr_gen.sv
// im2col read-address generator: walks oy,ox,ky,kx,c over an HWC tensor and emits
// one registered address beat per im2col element. Zero-padding support is built
// only when IM2COL_PAD_EN is defined; otherwise i_pad is ignored and o_pad is 0.
module im2col_addr_gen
  import im2col_pkg::*;
#(
  parameter int DIM_W  = CFG_DIM_W,
  parameter int K_W    = CFG_K_W,
  parameter int CH_W   = CFG_CH_W,
  parameter int S_W    = CFG_S_W,
  parameter int P_W    = CFG_P_W,
  parameter int ADDR_W = CFG_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_height,
  input  logic [DIM_W-1:0]  i_width,
  input  logic [CH_W-1:0]   i_channels,
  input  logic [K_W-1:0]    i_kernel,
  input  logic [S_W-1:0]    i_stride,
  input  logic [P_W-1:0]    i_pad,
  input  logic [ADDR_W-1:0] i_base,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  im2col_addr_gen_if.master bus
);

  localparam int CW = DIM_W + 2;

  state_t               state;
  cfg_t                 cfg_in, cfg_q, cfg;
  logic [CH_W-1:0]      c;
  logic                 valid_q, pad_q, last_q;
  logic [ADDR_W-1:0]    addr_q, pix, addr_calc;
  logic                 load_en, start_ok, step, c_last, beat_last, beat_pad;
  logic                 kx_adv, ky_adv, ox_adv, oy_adv;
  logic                 x_off_last, x_org_last, y_off_last, y_org_last;
  logic signed [CW-1:0] y_coord, x_coord;

  always_comb begin
    // NOTE: the whole struct is assigned before any field override, so no latch.
    cfg_in = '{height: i_height, width: i_width, channels: i_channels, kernel: i_kernel,
               stride: i_stride, pad: i_pad, base: i_base};
`ifndef IM2COL_PAD_EN
    cfg_in.pad = '0;
`endif
  end

  // While idle the walk runs off the live config so beat 0 loads on the start edge.
  assign cfg      = (state == IDLE) ? cfg_in : cfg_q;
  assign load_en  = !valid_q || bus.i_ready;
  assign start_ok = (state == IDLE) && i_start && cfg_legal(cfg_in);
  assign step     = start_ok || ((state == RUN) && load_en);

  assign c_last    = (c == cfg.channels - CH_W'(1));
  assign kx_adv    = step && c_last;
  assign ky_adv    = kx_adv && x_off_last;
  assign ox_adv    = ky_adv && y_off_last;
  assign oy_adv    = ox_adv && x_org_last;
  assign beat_last = c_last && x_off_last && y_off_last && x_org_last && y_org_last;

  im2col_win_cnt #(.DIM_W(DIM_W), .K_W(K_W), .S_W(S_W), .P_W(P_W)) u_y_cnt (
    .clk(clk), .rstn(rstn), .adv_off(ky_adv), .adv_org(oy_adv),
    .dim(cfg.height), .kernel(cfg.kernel), .stride(cfg.stride), .pad(cfg.pad),
    .coord(y_coord), .off_last(y_off_last), .org_last(y_org_last)
  );

  im2col_win_cnt #(.DIM_W(DIM_W), .K_W(K_W), .S_W(S_W), .P_W(P_W)) u_x_cnt (
    .clk(clk), .rstn(rstn), .adv_off(kx_adv), .adv_org(ox_adv),
    .dim(cfg.width), .kernel(cfg.kernel), .stride(cfg.stride), .pad(cfg.pad),
    .coord(x_coord), .off_last(x_off_last), .org_last(x_org_last)
  );

`ifdef IM2COL_PAD_EN
  assign beat_pad = y_coord[CW-1] || x_coord[CW-1] ||
                    (y_coord >= $signed(CW'(cfg.height))) ||
                    (x_coord >= $signed(CW'(cfg.width)));
`else
  logic unused_coord_msb;
  assign unused_coord_msb = ^{y_coord[CW-1:DIM_W], x_coord[CW-1:DIM_W]};
  assign beat_pad         = 1'b0;
`endif

  // Address wraps modulo 2^ADDR_W; only in-range coordinates reach it unmasked.
  assign pix       = ADDR_W'(y_coord[DIM_W-1:0]) * ADDR_W'(cfg.width) + ADDR_W'(x_coord[DIM_W-1:0]);
  assign addr_calc = cfg.base + pix * ADDR_W'(cfg.channels) + ADDR_W'(c);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cfg_q   <= '0;
      c       <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      pad_q   <= 1'b0;
      last_q  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (step) begin
        c       <= c_last ? '0 : c + CH_W'(1);
        valid_q <= 1'b1;
        addr_q  <= beat_pad ? '0 : addr_calc;
        pad_q   <= beat_pad;
        last_q  <= beat_last;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            cfg_q  <= cfg_in;
            o_busy <= 1'b1;
            state  <= beat_last ? DRAIN : RUN;
          end else if (i_start) begin
            o_err <= 1'b1;
          end
        end
        RUN: begin
          if (load_en && beat_last) state <= DRAIN;
        end
        DRAIN: begin
          if (bus.i_ready) begin
            valid_q <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_valid = valid_q;
  assign bus.o_addr  = addr_q;
  assign bus.o_pad   = pad_q;
  assign bus.o_last  = last_q;

endmodule

// File: tb/tb_im2col_addr_gen.sv
// Directed bench for im2col_addr_gen: full layers, padding, backpressure,
// illegal configs and mid-run reset, each checked against hand values and a loop model.
module tb_im2col_addr_gen;
  import im2col_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, i_start;
  logic [7:0]  i_height, i_width, i_channels;
  logic [3:0]  i_kernel, i_stride;
  logic [2:0]  i_pad;
  logic [23:0] i_base;
  logic        o_busy, o_done, o_err;

  int errors = 0;
  int checks = 0;

  logic [23:0] exp_addr[$];
  logic        exp_pad[$];
  logic [23:0] got_addr[$];
  logic        got_pad[$];
  logic        got_last[$];
  bit          done_seen;
  int          done_gap, stall_bad;

  im2col_addr_gen_if #(.ADDR_W(24)) bus ();

  im2col_addr_gen dut (
    .clk(clk), .rstn(rstn), .i_start(i_start),
    .i_height(i_height), .i_width(i_width), .i_channels(i_channels),
    .i_kernel(i_kernel), .i_stride(i_stride), .i_pad(i_pad), .i_base(i_base),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference walk written as plain nested loops over output windows.
  task automatic build_model(input int h, input int w, input int ch, input int k,
                             input int s, input int p, input logic [23:0] base);
    int pe;
`ifdef IM2COL_PAD_EN
    pe = p;
`else
    pe = 0;
`endif
    exp_addr.delete();
    exp_pad.delete();
    for (int oy = -pe; oy + k <= h + pe; oy += s)
      for (int ox = -pe; ox + k <= w + pe; ox += s)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++)
            for (int ci = 0; ci < ch; ci++) begin
              int y, x;
              bit pd;
              y  = oy + ky;
              x  = ox + kx;
              pd = (y < 0) || (y >= h) || (x < 0) || (x >= w);
              exp_pad.push_back(pd);
              exp_addr.push_back(pd ? 24'd0 : base + 24'((y * w + x) * ch + ci));
            end
  endtask

  task automatic start_layer(input int h, input int w, input int ch, input int k,
                             input int s, input int p, input logic [23:0] base);
    i_height   = 8'(h);
    i_width    = 8'(w);
    i_channels = 8'(ch);
    i_kernel   = 4'(k);
    i_stride   = 4'(s);
    i_pad      = 3'(p);
    i_base     = base;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Consumer: records accepted beats, watches stall stability and the done pulse.
  task automatic collect(input bit rand_ready, input int stop_after, input int poke_at);
    int          cycles, last_cyc;
    bit          held;
    logic [25:0] hold_v;
    cycles = 0; last_cyc = 0; held = 0; hold_v = '0;
    done_seen = 0; done_gap = -1; stall_bad = 0;
    got_addr.delete(); got_pad.delete(); got_last.delete();
    while (!done_seen && cycles < 5000 && got_addr.size() < stop_after) begin
      if (bus.o_valid && bus.i_ready) begin
        got_addr.push_back(bus.o_addr);
        got_pad.push_back(bus.o_pad);
        got_last.push_back(bus.o_last);
        last_cyc = cycles;
      end
      held   = bus.o_valid && !bus.i_ready;
      hold_v = {bus.o_addr, bus.o_pad, bus.o_last};
      @(posedge clk); #1;
      cycles++;
      if (held && (!bus.o_valid || {bus.o_addr, bus.o_pad, bus.o_last} !== hold_v)) stall_bad++;
      if (o_done) begin
        done_seen = 1;
        done_gap  = cycles - last_cyc;
      end
      bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_start     = (cycles == poke_at);
    end
    bus.i_ready = 1'b1;
    i_start     = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.o_valid, o_busy, o_done, o_err, bus.o_addr, bus.o_pad, bus.o_last} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b err=%b addr=%h, required all 0",
               bus.o_valid, o_busy, o_done, o_err, bus.o_addr);
    end
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    build_model(8, 8, 4, 2, 2, 0, 24'd0);
    start_layer(8, 8, 4, 2, 2, 0, 24'd0);
    checks++;
    if ({bus.o_valid, o_busy} !== 2'b11) begin
      errors++;
      $display("FAIL basic_first_beat: valid=%b busy=%b one cycle after start, required 1 1", bus.o_valid, o_busy);
    end
    collect(1'b0, 1 << 30, -1);
    checks++;
    if (got_addr.size() != 256) begin
      errors++;
      $display("FAIL basic_beat_count: got %0d, required 256", got_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if ({got_addr[i], got_pad[i], got_last[i]} !== {exp_addr[i], exp_pad[i], i == exp_addr.size() - 1}) begin
        errors++;
        $display("FAIL basic_beat %0d: addr=%h pad=%b last=%b, required addr=%h pad=%b last=%b", i,
                 got_addr[i], got_pad[i], got_last[i], exp_addr[i], exp_pad[i], i == exp_addr.size() - 1);
      end
    end
    for (int i = 0; i < 24 && i < got_addr.size(); i++) begin
      int hand;
      hand = (i < 8) ? i : (i < 16) ? i + 24 : i - 8;
      checks++;
      if (got_addr[i] !== 24'(hand)) begin
        errors++;
        $display("FAIL basic_hand_order beat %0d: addr=%0d, required %0d", i, got_addr[i], hand);
      end
    end
    checks++;
    if (got_addr.size() != 256 || got_addr[255] !== 24'd255 || got_last[255] !== 1'b1) begin
      errors++;
      $display("FAIL basic_last_beat: count=%0d, required beat 255 addr=255 with o_last", got_addr.size());
    end
    checks++;
    if (!done_seen || done_gap != 1) begin
      errors++;
      $display("FAIL basic_done: seen=%0d gap=%0d, required seen=1 gap=1", done_seen, done_gap);
    end
    @(posedge clk); #1;
    checks++;
    if ({o_busy, o_done, bus.o_valid} !== 3'b000) begin
      errors++;
      $display("FAIL basic_idle: busy=%b done=%b valid=%b, required 0 0 0", o_busy, o_done, bus.o_valid);
    end
  endtask

  task automatic test_pad();
    int npad;
    build_model(3, 3, 1, 3, 1, 1, 24'd0);
    start_layer(3, 3, 1, 3, 1, 1, 24'd0);
    collect(1'b0, 1 << 30, -1);
    npad = 0;
    for (int i = 0; i < got_pad.size(); i++) npad += int'(got_pad[i]);
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if ({got_addr[i], got_pad[i], got_last[i]} !== {exp_addr[i], exp_pad[i], i == exp_addr.size() - 1}) begin
        errors++;
        $display("FAIL pad_beat %0d: addr=%h pad=%b last=%b, required addr=%h pad=%b", i,
                 got_addr[i], got_pad[i], got_last[i], exp_addr[i], exp_pad[i]);
      end
    end
`ifdef IM2COL_PAD_EN
    checks++;
    if (got_addr.size() != 81 || npad != 32) begin
      errors++;
      $display("FAIL pad_counts: beats=%0d pads=%0d, required 81 and 32", got_addr.size(), npad);
    end
    checks++;
    if (got_addr.size() < 5 || {got_pad[0], got_addr[0], got_pad[4], got_addr[4]} !== {1'b1, 24'd0, 1'b0, 24'd0}) begin
      errors++;
      $display("FAIL pad_hand_beats: beat0 pad=%b addr=%h, beat4 pad=%b addr=%h, required 1/0 and 0/0",
               got_pad[0], got_addr[0], got_pad[4], got_addr[4]);
    end
`else
    checks++;
    if (got_addr.size() != 9 || npad != 0) begin
      errors++;
      $display("FAIL nopad_counts: beats=%0d pads=%0d, required 9 and 0", got_addr.size(), npad);
    end
    checks++;
    if (got_addr.size() < 9 || got_addr[4] !== 24'd4 || got_addr[8] !== 24'd8) begin
      errors++;
      $display("FAIL nopad_hand_beats: beat4=%h beat8=%h, required 4 and 8", got_addr[4], got_addr[8]);
    end
`endif
    checks++;
    if (!done_seen || done_gap != 1) begin
      errors++;
      $display("FAIL pad_done: seen=%0d gap=%0d, required seen=1 gap=1", done_seen, done_gap);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    build_model(8, 8, 4, 2, 2, 0, 24'd0);
    start_layer(8, 8, 4, 2, 2, 0, 24'd0);
    collect(1'b1, 1 << 30, -1);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL bp_beat_count: got %0d, required %0d", got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if ({got_addr[i], got_pad[i], got_last[i]} !== {exp_addr[i], exp_pad[i], i == exp_addr.size() - 1}) begin
        errors++;
        $display("FAIL bp_beat %0d: addr=%h last=%b, required addr=%h", i, got_addr[i], got_last[i], exp_addr[i]);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stall_stable: %0d stalled cycles changed outputs, required 0", stall_bad);
    end
    checks++;
    if (!done_seen || done_gap != 1) begin
      errors++;
      $display("FAIL bp_done: seen=%0d gap=%0d, required seen=1 gap=1", done_seen, done_gap);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_small();
    logic [23:0] bases[2];
    logic [23:0] hand_last[2];
    bases[0] = 24'd0;        hand_last[0] = 24'd18;
    bases[1] = 24'hFFFFFC;   hand_last[1] = 24'h00000E;
    for (int t = 0; t < 2; t++) begin
      build_model(5, 5, 1, 2, 2, 0, bases[t]);
      start_layer(5, 5, 1, 2, 2, 0, bases[t]);
      collect(1'b0, 1 << 30, -1);
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        checks++;
        if ({got_addr[i], got_last[i]} !== {exp_addr[i], i == exp_addr.size() - 1}) begin
          errors++;
          $display("FAIL small_beat base=%h %0d: addr=%h last=%b, required addr=%h", bases[t], i,
                   got_addr[i], got_last[i], exp_addr[i]);
        end
      end
      checks++;
      if (got_addr.size() != 16 || got_addr[15] !== hand_last[t] || got_addr[3] !== bases[t] + 24'd6) begin
        errors++;
        $display("FAIL small_hand base=%h: beats=%0d last=%h beat3=%h, required 16, %h, %h", bases[t],
                 got_addr.size(), got_addr[15], got_addr[3], hand_last[t], bases[t] + 24'd6);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    int ks[2];
    ks[0] = 0;
    ks[1] = 5;
    for (int t = 0; t < 2; t++) begin
      start_layer(4, 4, 1, ks[t], 1, 0, 24'd0);
      checks++;
      if ({o_err, bus.o_valid, o_busy} !== 3'b100) begin
        errors++;
        $display("FAIL illegal_k%0d_pulse: err=%b valid=%b busy=%b, required 1 0 0", ks[t], o_err, bus.o_valid, o_busy);
      end
      @(posedge clk); #1;
      checks++;
      if ({o_err, bus.o_valid, o_busy} !== 3'b000) begin
        errors++;
        $display("FAIL illegal_k%0d_after: err=%b valid=%b busy=%b, required 0 0 0", ks[t], o_err, bus.o_valid, o_busy);
      end
    end
  endtask

  task automatic test_abort_restart();
    build_model(8, 8, 4, 2, 2, 0, 24'd0);
    start_layer(8, 8, 4, 2, 2, 0, 24'd0);
    collect(1'b0, 10, -1);
    checks++;
    if (got_addr.size() != 10 || got_addr[9] !== exp_addr[9]) begin
      errors++;
      $display("FAIL abort_prefix: beats=%0d beat9=%h, required 10 and %h", got_addr.size(), got_addr[9], exp_addr[9]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.o_valid, o_busy, o_done, o_err, bus.o_addr, bus.o_pad, bus.o_last} !== 30'd0) begin
      errors++;
      $display("FAIL abort_outputs: valid=%b busy=%b done=%b err=%b addr=%h, required all 0",
               bus.o_valid, o_busy, o_done, o_err, bus.o_addr);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    start_layer(8, 8, 4, 2, 2, 0, 24'd0);
    collect(1'b0, 1 << 30, 40);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL restart_beat_count: got %0d, required %0d", got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if ({got_addr[i], got_last[i]} !== {exp_addr[i], i == exp_addr.size() - 1}) begin
        errors++;
        $display("FAIL restart_beat %0d: addr=%h last=%b, required addr=%h", i, got_addr[i], got_last[i], exp_addr[i]);
      end
    end
    checks++;
    if (!done_seen || done_gap != 1) begin
      errors++;
      $display("FAIL restart_done: seen=%0d gap=%0d, required seen=1 gap=1", done_seen, done_gap);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn        = 1'b0;
    i_start     = 1'b0;
    i_height    = '0;
    i_width     = '0;
    i_channels  = '0;
    i_kernel    = '0;
    i_stride    = '0;
    i_pad       = '0;
    i_base      = '0;
    bus.i_ready = 1'b1;
    test_reset();
    test_basic();
    test_pad();
    test_backpressure();
    test_small();
    test_illegal();
    test_abort_restart();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
